// File: rtl/fft_bin_unloader.sv
// fft_bin_unloader
//
// Streams the positive-frequency half of a completed FFT (bins 0 .. 2^(L-1)-1)
// out of the result RAM in natural order. For each bin it computes the squared
// magnitude, delivers {data, mag, idx} on a valid/ready stream and tracks the
// strongest non-DC bin for the tuner's pitch logic.
//
// Ports:
//   clk, reset       rising-edge clock, synchronous active-high reset
//   start            one-cycle pulse: FFT results are ready in the RAM
//   busy             high while a scan is in progress
//   rd_en, rd_addr   RAM read strobe / natural-order bin address
//   rd_data          RAM word {re, im}, valid one cycle after rd_en
//   out_data/mag/idx current beat: raw word, unsigned re^2+im^2, bin index
//   out_valid/ready  stream handshake; out_last marks the final bin
//   peak_idx/mag     strongest bin seen (bins 1..2^(L-1)-1), strict-greater
//   done             one-cycle pulse after the last beat is accepted
module fft_bin_unloader #(
    parameter int bit_width = 16,
    parameter int L         = 11
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic                   busy,
    output logic                   rd_en,
    output logic [L-1:0]           rd_addr,
    input  logic [2*bit_width-1:0] rd_data,
    output logic [2*bit_width-1:0] out_data,
    output logic [2*bit_width-1:0] out_mag,
    output logic [L-1:0]           out_idx,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic [L-1:0]           peak_idx,
    output logic [2*bit_width-1:0] peak_mag,
    output logic                   done
);

    localparam int W2 = 2 * bit_width;
    localparam logic [L-1:0] LAST_IDX = L'((1 << (L - 1)) - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Squared magnitude of a {re, im} word. Both components are sign-extended
    // to the full product width; the sum of two squares never exceeds
    // 2^(W2-1), so it fits in W2 unsigned bits.
    function automatic logic [W2-1:0] bin_mag(input logic [W2-1:0] word);
        logic signed [W2-1:0] re_ext;
        logic signed [W2-1:0] im_ext;
        logic signed [W2-1:0] re_sq;
        logic signed [W2-1:0] im_sq;
        re_ext = {{bit_width{word[W2-1]}}, word[W2-1:bit_width]};
        im_ext = {{bit_width{word[bit_width-1]}}, word[bit_width-1:0]};
        re_sq  = re_ext * re_ext;
        im_sq  = im_ext * im_ext;
        return $unsigned(re_sq) + $unsigned(im_sq);
    endfunction

    state_t        state_r;
    logic          rd_valid_r;     // RAM data returns this cycle
    logic [L-1:0]  rd_idx_r;       // bin index of the returning word
    logic          slot_valid_r;   // second FIFO entry (behind the head)
    logic          slot_last_r;
    logic [W2-1:0] slot_data_r;
    logic [W2-1:0] slot_mag_r;
    logic [L-1:0]  slot_idx_r;

    logic          pop_s;
    logic          push_s;
    logic          new_last_s;
    logic          peak_upd_s;
    logic [W2-1:0] new_mag_s;
    logic [2:0]    occ_s;

    // Handshake decode, read throttle and peak comparison.
    // occ_s is the worst-case FIFO occupancy one cycle from now if nothing
    // further is accepted: current entries, plus the word landing this cycle,
    // minus the beat leaving this cycle. A new read is only safe while that
    // stays below two, which still sustains one beat per cycle when the
    // consumer keeps up.
    always_comb begin
        pop_s      = out_valid & out_ready;
        push_s     = rd_valid_r;
        new_mag_s  = bin_mag(rd_data);
        new_last_s = (rd_idx_r == LAST_IDX);
        occ_s      = 3'(out_valid) + 3'(slot_valid_r) + 3'(rd_valid_r) - 3'(pop_s);
        peak_upd_s = pop_s && (out_idx != '0) && (out_mag > peak_mag);
        if (state_r == READ) begin
            rd_en = (occ_s < 3'd2);
        end else begin
            rd_en = 1'b0;
        end
    end

    // Control FSM: scan sequencing, address counter, peak tracking, done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= IDLE;
            busy     <= 1'b0;
            rd_addr  <= '0;
            done     <= 1'b0;
            peak_idx <= '0;
            peak_mag <= '0;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r  <= READ;
                        busy     <= 1'b1;
                        rd_addr  <= '0;
                        peak_idx <= '0;
                        peak_mag <= '0;
                    end
                end
                READ: begin
                    if (rd_en) begin
                        rd_addr <= rd_addr + L'(1);
                        if (rd_addr == LAST_IDX) begin
                            state_r <= DRAIN;
                        end
                    end
                    if (peak_upd_s) begin
                        peak_idx <= out_idx;
                        peak_mag <= out_mag;
                    end
                end
                DRAIN: begin
                    if (peak_upd_s) begin
                        peak_idx <= out_idx;
                        peak_mag <= out_mag;
                    end
                    if (pop_s && out_last) begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Read pipeline: remembers which bin the RAM is returning next cycle.
    // Clearing rd_valid_r on reset discards any word still in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid_r <= 1'b0;
            rd_idx_r   <= '0;
        end else begin
            rd_valid_r <= rd_en;
            if (rd_en) begin
                rd_idx_r <= rd_addr;
            end
        end
    end

    // Two-entry output FIFO. The head entry lives directly in the out_*
    // registers; slot_* holds the entry behind it.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid    <= 1'b0;
            out_last     <= 1'b0;
            out_data     <= '0;
            out_mag      <= '0;
            out_idx      <= '0;
            slot_valid_r <= 1'b0;
            slot_last_r  <= 1'b0;
            slot_data_r  <= '0;
            slot_mag_r   <= '0;
            slot_idx_r   <= '0;
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_last  <= new_last_s;
                        out_data  <= rd_data;
                        out_mag   <= new_mag_s;
                        out_idx   <= rd_idx_r;
                    end else begin
                        slot_valid_r <= 1'b1;
                        slot_last_r  <= new_last_s;
                        slot_data_r  <= rd_data;
                        slot_mag_r   <= new_mag_s;
                        slot_idx_r   <= rd_idx_r;
                    end
                end
                2'b01: begin
                    if (slot_valid_r) begin
                        out_last     <= slot_last_r;
                        out_data     <= slot_data_r;
                        out_mag      <= slot_mag_r;
                        out_idx      <= slot_idx_r;
                        slot_valid_r <= 1'b0;
                    end else begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                    end
                end
                2'b11: begin
                    if (slot_valid_r) begin
                        out_last    <= slot_last_r;
                        out_data    <= slot_data_r;
                        out_mag     <= slot_mag_r;
                        out_idx     <= slot_idx_r;
                        slot_last_r <= new_last_s;
                        slot_data_r <= rd_data;
                        slot_mag_r  <= new_mag_s;
                        slot_idx_r  <= rd_idx_r;
                    end else begin
                        out_last <= new_last_s;
                        out_data <= rd_data;
                        out_mag  <= new_mag_s;
                        out_idx  <= rd_idx_r;
                    end
                end
                default: begin
                    out_valid <= out_valid;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_bin_unloader.sv
// Self-checking bench for fft_bin_unloader (bit_width=16, L=11, 1024 bins).
// A behavioural RAM feeds the DUT; a reference model computes every bin's
// magnitude and the expected peak with plain integer arithmetic.
module tb_fft_bin_unloader;

    localparam int BW = 16;
    localparam int L  = 11;
    localparam int W2 = 32;
    localparam int NB = 1024;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          busy;
    logic          rd_en;
    logic [L-1:0]  rd_addr;
    logic [W2-1:0] rd_data;
    logic [W2-1:0] out_data;
    logic [W2-1:0] out_mag;
    logic [L-1:0]  out_idx;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic [L-1:0]  peak_idx;
    logic [W2-1:0] peak_mag;
    logic          done;

    int tests = 0;
    int fails = 0;

    logic [W2-1:0] ram     [0:(1<<L)-1];
    logic [W2-1:0] got_mag [0:NB-1];

    typedef struct {
        logic [15:0] re;
        logic [15:0] im;
        logic [31:0] mag;
    } vec_t;
    vec_t vecs [0:7];

    fft_bin_unloader #(.bit_width(BW), .L(L)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .out_data(out_data), .out_mag(out_mag), .out_idx(out_idx),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .peak_idx(peak_idx), .peak_mag(peak_mag), .done(done)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM model: word valid the cycle after rd_en.
    always @(posedge clk) begin
        if (rd_en) rd_data <= ram[rd_addr];
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic longint ref_mag(input logic [W2-1:0] w);
        int re;
        int im;
        re = $signed(w[31:16]);
        im = $signed(w[15:0]);
        return longint'(re) * re + longint'(im) * im;
    endfunction

    task automatic clear_ram();
        for (int k = 0; k < (1 << L); k++) ram[k] = '0;
    endtask

    // One full scan. timing=1 requires out_ready held high and checks the
    // exact cycle schedule; extra_cyc>0 re-pulses start while busy.
    task automatic run_stream(input int ready_pct, input bit timing, input int extra_cyc, input string tag);
        logic [W2-1:0] exp_word [$];
        int            exp_idx  [$];
        logic [W2-1:0] ew;
        int            ei;
        longint        pk_mag;
        int            pk_idx;
        int            beats, dones, done_cyc, last_cyc, issued, xfer, max_out, unstable;
        bit            hold;
        logic [W2-1:0] pd, pm;
        logic [L-1:0]  pi;
        pk_mag = 0; pk_idx = 0; beats = 0; dones = 0; done_cyc = -1; last_cyc = -1;
        issued = 0; xfer = 0; max_out = 0; unstable = 0; hold = 1'b0;
        pd = '0; pm = '0; pi = '0;
        for (int k = 0; k < NB; k++) begin
            exp_word.push_back(ram[k]);
            exp_idx.push_back(k);
            if (k != 0 && ref_mag(ram[k]) > pk_mag) begin
                pk_mag = ref_mag(ram[k]);
                pk_idx = k;
            end
        end
        @(posedge clk); #1;
        start = 1'b1;
        out_ready = 1'b1;
        for (int cyc = 1; cyc <= 8000; cyc++) begin
            @(posedge clk); #1;
            start = (cyc == extra_cyc);
            out_ready = ($urandom_range(0, 99) < ready_pct);
            #1;
            if (timing && cyc == 1) begin
                check({tag, " c1 busy"}, busy, 1'b1);
                check({tag, " c1 rd_en"}, rd_en, 1'b1);
                check({tag, " c1 rd_addr"}, rd_addr, 0);
            end
            if (timing && cyc == 2) check({tag, " c2 out_valid"}, out_valid, 1'b0);
            if (timing && cyc == 3) begin
                check({tag, " c3 out_valid"}, out_valid, 1'b1);
                check({tag, " c3 out_idx"}, out_idx, 0);
            end
            if (hold && (!out_valid || out_data !== pd || out_mag !== pm || out_idx !== pi)) unstable++;
            hold = out_valid && !out_ready;
            pd = out_data; pm = out_mag; pi = out_idx;
            if (rd_en) issued++;
            if (out_valid && out_ready) begin
                xfer++;
                if (exp_idx.size() == 0) begin
                    check({tag, " surplus beat"}, 1'b1, 1'b0);
                end else begin
                    ew = exp_word.pop_front();
                    ei = exp_idx.pop_front();
                    check({tag, " beat idx"}, out_idx, ei);
                    check({tag, " beat data"}, out_data, ew);
                    check({tag, " beat mag"}, out_mag, ref_mag(ew));
                    check({tag, " beat last"}, out_last, (ei == NB - 1));
                    got_mag[beats] = out_mag;
                    beats++;
                    if (ei == NB - 1) last_cyc = cyc;
                end
            end
            if (issued - xfer > max_out) max_out = issued - xfer;
            if (done) begin
                dones++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    check({tag, " busy at done"}, busy, 1'b0);
                end
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 4) break;
        end
        if (done_cyc < 0) check({tag, " done timeout"}, 1'b0, 1'b1);
        check({tag, " beat count"}, beats, NB);
        check({tag, " done count"}, dones, 1);
        check({tag, " outstanding<=2"}, (max_out <= 2), 1'b1);
        check({tag, " stall stability"}, unstable, 0);
        check({tag, " peak_idx"}, peak_idx, pk_idx);
        check({tag, " peak_mag"}, peak_mag, pk_mag);
        check({tag, " busy after"}, busy, 1'b0);
        if (timing) begin
            check({tag, " last beat cycle"}, last_cyc, NB + 2);
            check({tag, " done cycle"}, done_cyc, NB + 3);
        end
    endtask

    initial begin
        int  n;
        bit  hit;
        vecs[0] = '{16'h8000, 16'h8000, 32'h8000_0000};
        vecs[1] = '{16'h7FFF, 16'h0000, 32'h3FFF_0001};
        vecs[2] = '{16'h1000, 16'h1000, 32'h0200_0000};
        vecs[3] = '{16'hFFFF, 16'h0001, 32'h0000_0002};
        vecs[4] = '{16'h0003, 16'h0004, 32'h0000_0019};
        vecs[5] = '{16'hFFFD, 16'hFFFC, 32'h0000_0019};
        vecs[6] = '{16'h0000, 16'h0000, 32'h0000_0000};
        vecs[7] = '{16'h8000, 16'h0000, 32'h4000_0000};

        reset = 1'b1; start = 1'b0; out_ready = 1'b0;
        clear_ram();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("reset busy", busy, 1'b0);
        check("reset rd_en", rd_en, 1'b0);
        check("reset rd_addr", rd_addr, 0);
        check("reset out_valid", out_valid, 1'b0);
        check("reset out_last", out_last, 1'b0);
        check("reset out_data", out_data, 0);
        check("reset out_mag", out_mag, 0);
        check("reset out_idx", out_idx, 0);
        check("reset peak_idx", peak_idx, 0);
        check("reset peak_mag", peak_mag, 0);
        check("reset done", done, 1'b0);

        // Magnitude table: extremes, signs, DC excluded from the peak.
        for (int i = 0; i < 8; i++) ram[i] = {vecs[i].re, vecs[i].im};
        run_stream(100, 1'b1, 0, "table");
        for (int i = 0; i < 8; i++) check("table mag", got_mag[i], vecs[i].mag);
        check("table peak_idx", peak_idx, 7);

        // Impulse ramp.
        for (int k = 0; k < NB; k++) ram[k] = {16'(k), 16'h0000};
        run_stream(100, 1'b1, 0, "impulse");
        check("impulse peak_idx", peak_idx, 1023);
        check("impulse mag 1023", got_mag[1023], 32'd1046529);

        // Tone + DC.
        clear_ram();
        ram[0]  = {16'h7FFF, 16'h0000};
        ram[37] = {16'h1000, 16'h1000};
        run_stream(100, 1'b1, 0, "tone");
        check("tone peak_idx", peak_idx, 37);
        check("tone peak_mag", peak_mag, 32'h0200_0000);

        // Extreme tie: lower index wins.
        clear_ram();
        ram[5] = {16'h8000, 16'h8000};
        ram[9] = {16'h8000, 16'h8000};
        run_stream(100, 1'b1, 0, "tie");
        check("tie mag 5", got_mag[5], 32'h8000_0000);
        check("tie mag 9", got_mag[9], 32'h8000_0000);
        check("tie peak_idx", peak_idx, 5);

        // Random spectrum under heavy backpressure.
        for (int k = 0; k < NB; k++) ram[k] = $urandom();
        run_stream(30, 1'b0, 0, "backpressure");

        // start re-pulsed while busy must be ignored.
        for (int k = 0; k < NB; k++) ram[k] = $urandom();
        run_stream(100, 1'b1, 50, "start_busy");

        // Reset at beat 100 with a beat on the output.
        for (int k = 0; k < NB; k++) ram[k] = {16'(k), 16'h0000};
        n = 0; hit = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; out_ready = 1'b1;
        for (int cyc = 1; cyc <= 2000; cyc++) begin
            @(posedge clk); #1;
            start = 1'b0;
            #1;
            if (out_valid && out_ready) n++;
            if (n == 100 && out_valid) begin
                reset = 1'b1;
                hit = 1'b1;
                break;
            end
        end
        check("reset point reached", hit, 1'b1);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("midreset out_valid", out_valid, 1'b0);
        check("midreset busy", busy, 1'b0);
        check("midreset peak_mag", peak_mag, 0);
        check("midreset peak_idx", peak_idx, 0);
        check("midreset rd_en", rd_en, 1'b0);
        check("midreset out_idx", out_idx, 0);
        check("midreset done", done, 1'b0);
        @(posedge clk); #2;
        check("midreset inflight dropped", out_valid, 1'b0);
        run_stream(100, 1'b1, 0, "restart");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
